instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the reset port SHALL be named rst and SHALL reset the block at a clk rising edge while rst==0.
REQ-002 Parameter WIDTH, default 32, SHALL be the address/PC width.
REQ-003 Parameter DEPTH, default 4, SHALL be the queue entry count and SHALL be a power of two, at least 2.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 pc_in  in  WIDTH  fetch address from the PC stage.
REQ-007 pc_valid  in  1  pc_in is valid this cycle.
REQ-008 pc_ready  out  1  fetch address is accepted this cycle.
REQ-009 flush  in  1  taken branch (PCsrc); discards all queued and in-flight fetches.
REQ-010 imem_req  out  1  instruction-memory read request.
REQ-011 imem_addr  out  WIDTH  read address, held stable while imem_req==1.
REQ-012 imem_ack  in  1  read data valid; one cycle per request.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 instr_out  out  32  instruction presented to decode.
REQ-015 instr_pc  out  WIDTH  PC of instr_out.
REQ-016 instr_valid  out  1  queue head is valid.
REQ-017 instr_ready  in  1  decode consumes the queue head.

Function
REQ-018 FSM states SHALL be IDLE (no request outstanding), WAIT (request outstanding) and DROP (flushed request outstanding, response to be discarded).
REQ-019 pc_ready SHALL equal (state==IDLE) && (count<DEPTH) && !flush.
REQ-020 In IDLE, pc_valid&&pc_ready SHALL register pc_in into imem_addr, assert imem_req from the next cycle, and move the FSM to WAIT.
REQ-021 In WAIT, imem_ack SHALL push {imem_rdata, imem_addr} into the queue in the same edge, deassert imem_req, and return the FSM to IDLE.
REQ-022 At most one memory request SHALL be outstanding at a time.
REQ-023 Minimum latency from pc accept to instr_valid SHALL be 2 cycles when imem_ack arrives in the first WAIT cycle.
REQ-024 instr_valid SHALL equal (count!=0); instr_out/instr_pc SHALL show the head entry combinationally from registered storage.
REQ-025 A pop SHALL occur on instr_valid&&instr_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-028 A pop with the queue empty SHALL be ignored.
REQ-029 Pushes SHALL never overflow the queue; this SHALL be guaranteed by REQ-019.
REQ-030 flush SHALL clear count and both pointers on the same edge, and SHALL ignore any simultaneous pop or push.
REQ-031 If flush is asserted in WAIT without imem_ack, imem_req SHALL deassert and the FSM SHALL go to DROP.
REQ-032 If flush and imem_ack occur in the same WAIT cycle, the data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-033 In DROP, imem_ack SHALL be discarded and the FSM SHALL return to IDLE; pc_ready SHALL be 0 while in DROP.
REQ-034 A flush in IDLE or DROP SHALL only clear the queue.

Reset
REQ-035 While rst==0 at a clock edge: state=IDLE, count=0, pointers=0, imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0.
REQ-036 Reset SHALL take priority over flush, and any in-flight memory response SHALL be abandoned.
REQ-037 The next imem_ack after reset SHALL be ignored unless the post-reset FSM is in WAIT.
REQ-038 Queue storage contents are not required to reset.

Verification
REQ-039 Basic fetch: pc_in=0x0 accepted, imem_ack one cycle later with 0x00500093 -> instr_valid=1 with instr_out=0x00500093, instr_pc=0x0, 2 cycles after accept.
REQ-040 Fill: instr_ready=0, four fetches 0x0, 0x4, 0x8, 0xC -> count=4, pc_ready=0; then pop 4 -> PCs come out in order 0x0, 0x4, 0x8, 0xC, and the pointers have wrapped.
REQ-041 Flush in WAIT: request for 0x10 outstanding, flush=1 -> FSM=DROP, pc_ready=0; a later imem_ack is not queued; instr_valid=0.
REQ-042 Same-cycle flush+ack: flush with imem_ack for 0x14 -> no entry is queued, FSM=IDLE, and pc_ready=1 next cycle.
REQ-043 Simultaneous push/pop with count=2 -> count stays 2 and the head advances by one entry.
REQ-044 Reset mid-WAIT: rst=0 for one edge -> all outputs take their REQ-035 values; a following stray imem_ack does not set instr_valid.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one instruction-memory read at a time and buffers
// returned words with their PCs in a small FIFO for decode; flush discards all fetches.
module instr_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t           state;
  logic [31:0]      instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             accept;
  logic             push;
  logic             pop;

  assign pc_ready    = (state == IDLE) && (count < FULL) && !flush;
  assign accept      = pc_valid && pc_ready;
  assign push        = (state == WAIT) && imem_ack && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr_valid = (count != '0);
  // Head is masked while empty so unreset storage never leaks onto the outputs.
  assign instr_out   = instr_valid ? instr_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // An ack in the flush cycle completes the request; its data is just not queued.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (flush) begin
            imem_req <= 1'b0;
            state    <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= imem_addr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a randomized run
// compared against a transaction-level queue model.
module tb_instr_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] pc_in = '0;
  logic             pc_valid = 1'b0;
  logic             pc_ready;
  logic             flush = 1'b0;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic [31:0]      instr_out;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready = 1'b0;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference model: a list of queued fetches plus "request outstanding" / "response to drop".
  ent_t        q[$];
  bit          busy = 0;
  bit          dropping = 0;
  logic [31:0] maddr = '0;

  instr_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    return !busy && !dropping && (q.size() < DEPTH) && !flush;
  endfunction

  task automatic set_in(input logic pv, input logic [31:0] pin, input logic fl,
                        input logic ack, input logic [31:0] rd, input logic rdy);
    pc_valid = pv; pc_in = pin; flush = fl; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
    #1;
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    bit acc, popped, pushed;
    acc    = model_ready() && pc_valid;
    popped = (q.size() != 0) && instr_ready && !flush;
    pushed = busy && imem_ack && !flush;
    @(posedge clk);
    if (!rst) begin
      q.delete(); busy = 0; dropping = 0; maddr = '0;
    end else begin
      if (flush) q.delete();
      else begin
        if (popped) void'(q.pop_front());
        if (pushed) q.push_back('{pc: maddr, ins: imem_rdata});
      end
      if (busy) begin
        if (imem_ack) busy = 0;
        else if (flush) begin busy = 0; dropping = 1; end
      end else if (dropping) begin
        if (imem_ack) dropping = 0;
      end else if (acc) begin
        busy = 1; maddr = pc_in;
      end
    end
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    set_in(1, addr, 0, 0, 0, rdy); tick();
    set_in(0, 0, 0, 1, data, rdy); tick();
    set_in(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic test_reset();
    rst = 0; set_in(1, 32'h1234, 0, 1, 32'hFFFF_FFFF, 1); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL reset_head got %h/%h want 0/0", instr_out, instr_pc); end
    rst = 1; #1;
    checks++; if (pc_ready !== 1'b1) begin fails++; $display("FAIL reset_pc_ready got %b want 1", pc_ready); end
  endtask

  task automatic test_basic_fetch();
    set_in(1, 32'h0, 0, 0, 0, 0);
    checks++; if (pc_ready !== 1'b1) begin fails++; $display("FAIL basic_accept got %b want 1", pc_ready); end
    tick();
    set_in(0, 0, 0, 1, 32'h0050_0093, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL basic_req got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (pc_ready !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL basic_wait got rdy=%b vld=%b want 0/0", pc_ready, instr_valid); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h0050_0093 || instr_pc !== 32'h0) begin
      fails++; $display("FAIL basic_out got %b/%h/%h want 1/00500093/0", instr_valid, instr_out, instr_pc); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_req_drop got %b want 0", imem_req); end
    set_in(0, 0, 0, 0, 0, 1); tick(); set_in(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL basic_pop got %b want 0", instr_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) do_fetch(32'(i * 4), 32'h1000 + 32'(i), 0);
    set_in(1, 32'h40, 0, 0, 0, 0);
    checks++; if (pc_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready got %b want 0", pc_ready); end
    checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL fill_valid got %b want 1", instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fill_no_req got %b want 0", imem_req); end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1);
      checks++; if (instr_pc !== 32'(i * 4) || instr_out !== 32'h1000 + 32'(i)) begin
        fails++; $display("FAIL fill_order_%0d got %h/%h want %h/%h", i, instr_pc, instr_out, i * 4, 32'h1000 + i); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 1);
    checks++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin fails++; $display("FAIL fill_drained got vld=%b rdy=%b want 0/1", instr_valid, pc_ready); end
    tick();
    do_fetch(32'h50, 32'hABCD_0001, 0);
    checks++; if (instr_pc !== 32'h50 || instr_out !== 32'hABCD_0001) begin fails++; $display("FAIL fill_wrap got %h/%h want 50/abcd0001", instr_pc, instr_out); end
    set_in(0, 0, 0, 0, 0, 1); tick(); set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h20, 32'hD000_0000, 0);
    do_fetch(32'h24, 32'hD000_0001, 0);
    set_in(1, 32'h28, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 32'hD000_0002, 1);
    checks++; if (instr_pc !== 32'h20) begin fails++; $display("FAIL b2b_head0 got %h want 20", instr_pc); end
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    checks++; if (instr_pc !== 32'h24 || instr_out !== 32'hD000_0001) begin fails++; $display("FAIL b2b_head1 got %h/%h want 24/d0000001", instr_pc, instr_out); end
    tick();
    checks++; if (instr_pc !== 32'h28 || instr_out !== 32'hD000_0002) begin fails++; $display("FAIL b2b_head2 got %h/%h want 28/d0000002", instr_pc, instr_out); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_count got %b want 0", instr_valid); end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_wait();
    do_fetch(32'h08, 32'h1111_1111, 0);
    set_in(1, 32'h10, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 0, 0, 0);
    checks++; if (pc_ready !== 1'b0) begin fails++; $display("FAIL flushw_ready_in_flush got %b want 0", pc_ready); end
    tick();
    set_in(1, 32'h60, 0, 0, 0, 0);
    checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL flushw_drop got rdy=%b req=%b want 0/0", pc_ready, imem_req); end
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL flushw_cleared got %b want 0", instr_valid); end
    tick();
    set_in(0, 0, 0, 1, 32'hBAD0_0010, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin fails++; $display("FAIL flushw_ack_dropped got vld=%b rdy=%b want 0/1", instr_valid, pc_ready); end
  endtask

  task automatic test_flush_ack();
    set_in(1, 32'h14, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 1, 32'hBAD0_0014, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1 || imem_req !== 1'b0) begin
      fails++; $display("FAIL flushack got vld=%b rdy=%b req=%b want 0/1/0", instr_valid, pc_ready, imem_req); end
  endtask

  task automatic test_reset_mid_wait();
    do_fetch(32'h2C, 32'h2222_2222, 0);
    set_in(1, 32'h30, 0, 0, 0, 0); tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin fails++; $display("FAIL rstw_pre got req=%b vld=%b want 1/1", imem_req, instr_valid); end
    rst = 0; set_in(0, 0, 1, 0, 0, 0); tick();
    rst = 1; set_in(0, 0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      fails++; $display("FAIL rstw_outputs got req=%b addr=%h vld=%b out=%h pc=%h want all 0", imem_req, imem_addr, instr_valid, instr_out, instr_pc); end
    set_in(0, 0, 0, 1, 32'hDEAD_BEEF, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin fails++; $display("FAIL rstw_stray_ack got vld=%b rdy=%b want 0/1", instr_valid, pc_ready); end
  endtask

  task automatic test_random();
    logic pv, fl, ack, rdy;
    logic exp_rdy;
    for (int n = 0; n < 800; n++) begin
      pv  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      ack = (busy || dropping) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rdy = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_in(pv, $urandom & 32'hFFFF_FFFC, fl, ack, $urandom, rdy);
      exp_rdy = model_ready();
      checks++; if (pc_ready !== exp_rdy) begin fails++; $display("FAIL rnd_pc_ready[%0d] got %b want %b", n, pc_ready, exp_rdy); end
      checks++; if (instr_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", n, instr_valid, q.size() != 0); end
      checks++; if (imem_req !== busy) begin fails++; $display("FAIL rnd_req[%0d] got %b want %b", n, imem_req, busy); end
      if (busy) begin
        checks++; if (imem_addr !== maddr) begin fails++; $display("FAIL rnd_addr[%0d] got %h want %h", n, imem_addr, maddr); end
      end
      if (q.size() != 0) begin
        checks++; if (instr_pc !== q[0].pc || instr_out !== q[0].ins) begin
          fails++; $display("FAIL rnd_head[%0d] got %h/%h want %h/%h", n, instr_pc, instr_out, q[0].pc, q[0].ins); end
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_fill();
    test_back_to_back();
    test_flush_wait();
    test_flush_ack();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
